// File: rtl/bp_fe_bht_ctrl.sv
// Single-port BHT access controller: buffers branch updates in a FIFO,
// arbitrates them against prediction reads, and sequences table clear sweeps.
module bp_fe_bht_ctrl #(
    parameter int unsigned bht_idx_width_p = 8,
    parameter int unsigned upd_fifo_els_p  = 4,
    parameter int unsigned max_starve_p    = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    output logic                       busy_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] r_idx_i,
    output logic                       r_ready_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic                       w_correct_i,
    output logic                       w_ready_o,
    output logic                       bht_r_v_o,
    output logic [bht_idx_width_p-1:0] bht_idx_r_o,
    output logic                       bht_w_v_o,
    output logic [bht_idx_width_p-1:0] bht_idx_w_o,
    output logic                       bht_correct_o,
    output logic                       bht_clr_v_o,
    output logic [bht_idx_width_p-1:0] bht_clr_idx_o
);

    localparam int unsigned ptr_w_lp    = $clog2(upd_fifo_els_p);
    localparam int unsigned starve_w_lp = $clog2(max_starve_p + 1);
    localparam logic [ptr_w_lp:0]      full_cnt_lp   = (ptr_w_lp + 1)'(upd_fifo_els_p);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(max_starve_p);

    typedef enum logic {INIT, RUN} state_e;

    state_e                       state_q, state_d;
    logic [bht_idx_width_p-1:0]   sweep_q, sweep_d;
    logic [ptr_w_lp-1:0]          rptr_q, rptr_d, wptr_q, wptr_d;
    logic [ptr_w_lp:0]            count_q, count_d;
    logic [starve_w_lp-1:0]       starve_q, starve_d;
    logic [bht_idx_width_p:0]     mem_q [upd_fifo_els_p];
    logic [bht_idx_width_p:0]     mem_d [upd_fifo_els_p];

    logic full, empty, enq, write_sel;

    assign full          = (count_q == full_cnt_lp);
    assign empty         = (count_q == '0);
    assign busy_o        = reset_i | (state_q == INIT);
    assign bht_idx_r_o   = r_idx_i;
    assign bht_clr_idx_o = sweep_q;
    assign bht_idx_w_o   = mem_q[rptr_q][bht_idx_width_p:1];
    assign bht_correct_o = mem_q[rptr_q][0];

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        mem_d       = mem_q;
        enq         = 1'b0;
        write_sel   = 1'b0;
        r_ready_o   = 1'b0;
        w_ready_o   = 1'b0;
        bht_r_v_o   = 1'b0;
        bht_w_v_o   = 1'b0;
        bht_clr_v_o = 1'b0;

        case (state_q)
            INIT: begin
                bht_clr_v_o = 1'b1;
                starve_d    = '0;
                if (flush_i) begin
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == '1) state_d = RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d  = INIT;
                    sweep_d  = '0;
                    rptr_d   = '0;
                    wptr_d   = '0;
                    count_d  = '0;
                    starve_d = '0;
                end else begin
                    w_ready_o = ~full;
                    enq       = w_v_i & ~full;
                    write_sel = ~empty & (~r_v_i | full | (starve_q == starve_max_lp));
                    if (enq) begin
                        mem_d[wptr_q] = {w_idx_i, w_correct_i};
                        wptr_d        = wptr_q + 1'b1;
                    end
                    if (write_sel) begin
                        bht_w_v_o = 1'b1;
                        rptr_d    = rptr_q + 1'b1;
                    end else begin
                        r_ready_o = 1'b1;
                        bht_r_v_o = r_v_i;
                    end
                    // Occupancy seen by w_ready_o is registered, so a dequeue never frees a slot for this cycle's enqueue.
                    if (enq && !write_sel)      count_d = count_q + 1'b1;
                    else if (!enq && write_sel) count_d = count_q - 1'b1;
                    if (write_sel || empty)     starve_d = '0;
                    else if (starve_q != starve_max_lp) starve_d = starve_q + 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        if (reset_i) begin
            r_ready_o   = 1'b0;
            w_ready_o   = 1'b0;
            bht_r_v_o   = 1'b0;
            bht_w_v_o   = 1'b0;
            bht_clr_v_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= INIT;
            sweep_q  <= '0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Directed bench for bp_fe_bht_ctrl with an 8-entry table and a 4-deep update FIFO.
module tb_bp_fe_bht_ctrl;

    localparam int unsigned W = 3;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         flush_i = 1'b0;
    logic         busy_o;
    logic         r_v_i = 1'b0;
    logic [W-1:0] r_idx_i = '0;
    logic         r_ready_o;
    logic         w_v_i = 1'b0;
    logic [W-1:0] w_idx_i = '0;
    logic         w_correct_i = 1'b0;
    logic         w_ready_o;
    logic         bht_r_v_o;
    logic [W-1:0] bht_idx_r_o;
    logic         bht_w_v_o;
    logic [W-1:0] bht_idx_w_o;
    logic         bht_correct_o;
    logic         bht_clr_v_o;
    logic [W-1:0] bht_clr_idx_o;

    int checks = 0;
    int failures = 0;

    // {busy, r_ready, w_ready, bht_r_v, bht_w_v, bht_clr_v}
    logic [5:0]   flags;
    logic [W:0]   wr;
    assign flags = {busy_o, r_ready_o, w_ready_o, bht_r_v_o, bht_w_v_o, bht_clr_v_o};
    assign wr    = {bht_idx_w_o, bht_correct_o};

    bp_fe_bht_ctrl #(
        .bht_idx_width_p(W),
        .upd_fifo_els_p (4),
        .max_starve_p   (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .r_v_i        (r_v_i),
        .r_idx_i      (r_idx_i),
        .r_ready_o    (r_ready_o),
        .w_v_i        (w_v_i),
        .w_idx_i      (w_idx_i),
        .w_correct_i  (w_correct_i),
        .w_ready_o    (w_ready_o),
        .bht_r_v_o    (bht_r_v_o),
        .bht_idx_r_o  (bht_idx_r_o),
        .bht_w_v_o    (bht_w_v_o),
        .bht_idx_w_o  (bht_idx_w_o),
        .bht_correct_o(bht_correct_o),
        .bht_clr_v_o  (bht_clr_v_o),
        .bht_clr_idx_o(bht_clr_idx_o)
    );

    always #5 clk_i = ~clk_i;

    // Apply one cycle's inputs just after the rising edge, then let outputs settle.
    task automatic drive(input logic rst, input logic fl, input logic rv, input logic [W-1:0] ri,
                         input logic wv, input logic [W-1:0] wi, input logic wc);
        @(posedge clk_i);
        #1;
        reset_i = rst; flush_i = fl; r_v_i = rv; r_idx_i = ri;
        w_v_i = wv; w_idx_i = wi; w_correct_i = wc;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 3'd1, 1, 3'd2, 1);
            checks++;
            if (flags !== 6'b100000) begin
                failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 6'b100000);
            end
        end
    endtask

    task automatic test_sweep();
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 1, 3'd3, 1, 3'd6, 1);
            checks++;
            if (flags !== 6'b100001) begin
                failures++; $display("FAIL sweep_flags c=%0d got=%b exp=%b", c, flags, 6'b100001);
            end
            checks++;
            if (bht_clr_idx_o !== W'(c)) begin
                failures++; $display("FAIL sweep_idx got=%0d exp=%0d", bht_clr_idx_o, c);
            end
        end
        drive(0, 0, 1, 3'd5, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011100) begin
            failures++; $display("FAIL sweep_exit_flags got=%b exp=%b", flags, 6'b011100);
        end
        checks++;
        if (bht_idx_r_o !== 3'd5) begin
            failures++; $display("FAIL sweep_exit_ridx got=%0d exp=5", bht_idx_r_o);
        end
    endtask

    task automatic test_idle_drain();
        drive(0, 0, 0, 3'd0, 1, 3'd5, 1);
        checks++;
        if (flags !== 6'b011000) begin
            failures++; $display("FAIL drain_enq_flags got=%b exp=%b", flags, 6'b011000);
        end
        drive(0, 0, 0, 3'd0, 1, 3'd2, 0);
        checks++;
        if (flags !== 6'b001010 || wr !== 4'b1011) begin
            failures++; $display("FAIL drain_first got=%b/%b exp=%b/%b", flags, wr, 6'b001010, 4'b1011);
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b001010 || wr !== 4'b0100) begin
            failures++; $display("FAIL drain_second got=%b/%b exp=%b/%b", flags, wr, 6'b001010, 4'b0100);
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011000) begin
            failures++; $display("FAIL drain_empty got=%b exp=%b", flags, 6'b011000);
        end
    endtask

    task automatic test_read_priority();
        drive(0, 0, 1, 3'd1, 1, 3'd3, 1);
        for (int c = 1; c <= 8; c++) begin
            drive(0, 0, 1, 3'd1, 0, 3'd0, 0);
            checks++;
            if (flags !== 6'b011100) begin
                failures++; $display("FAIL starve_read c=%0d got=%b exp=%b", c, flags, 6'b011100);
            end
        end
        drive(0, 0, 1, 3'd1, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b001010 || wr !== 4'b0111) begin
            failures++; $display("FAIL starve_force got=%b/%b exp=%b/%b", flags, wr, 6'b001010, 4'b0111);
        end
        drive(0, 0, 1, 3'd6, 1, 3'd6, 0);
        drive(0, 0, 1, 3'd6, 0, 3'd0, 0);
        drive(0, 0, 1, 3'd6, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011100) begin
            failures++; $display("FAIL rdrop_read got=%b exp=%b", flags, 6'b011100);
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b001010 || wr !== 4'b1100) begin
            failures++; $display("FAIL rdrop_write got=%b/%b exp=%b/%b", flags, wr, 6'b001010, 4'b1100);
        end
    endtask

    task automatic test_full_fifo();
        logic [W:0] exp_q [4];
        exp_q[0] = 4'b0011; exp_q[1] = 4'b1000; exp_q[2] = 4'b1111; exp_q[3] = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 3'd2, 1, exp_q[i][W:1], exp_q[i][0]);
            checks++;
            if (flags !== 6'b011100) begin
                failures++; $display("FAIL full_fill i=%0d got=%b exp=%b", i, flags, 6'b011100);
            end
        end
        drive(0, 0, 1, 3'd2, 1, 3'd0, 0);
        checks++;
        if (flags !== 6'b000010 || wr !== exp_q[0]) begin
            failures++; $display("FAIL full_force got=%b/%b exp=%b/%b", flags, wr, 6'b000010, exp_q[0]);
        end
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
            checks++;
            if (flags !== 6'b001010 || wr !== exp_q[i]) begin
                failures++; $display("FAIL full_order i=%0d got=%b/%b exp=%b/%b", i, flags, wr, 6'b001010, exp_q[i]);
            end
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011000) begin
            failures++; $display("FAIL full_rejected got=%b exp=%b", flags, 6'b011000);
        end
    endtask

    task automatic test_flush_run();
        for (int i = 1; i <= 3; i++) drive(0, 0, 1, 3'd0, 1, W'(i), 1);
        drive(0, 1, 1, 3'd0, 1, 3'd4, 1);
        checks++;
        if (flags !== 6'b000000) begin
            failures++; $display("FAIL flush_suppress got=%b exp=%b", flags, 6'b000000);
        end
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
            checks++;
            if (flags !== 6'b100001 || bht_clr_idx_o !== W'(c)) begin
                failures++; $display("FAIL flush_sweep c=%0d got=%b/%0d exp=%b/%0d", c, flags, bht_clr_idx_o, 6'b100001, c);
            end
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011000) begin
            failures++; $display("FAIL flush_empty got=%b exp=%b", flags, 6'b011000);
        end
    endtask

    task automatic test_flush_init();
        drive(0, 1, 0, 3'd0, 0, 3'd0, 0);
        for (int c = 0; c < 4; c++) drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        drive(0, 1, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b100001 || bht_clr_idx_o !== 3'd4) begin
            failures++; $display("FAIL finit_at4 got=%b/%0d exp=%b/4", flags, bht_clr_idx_o, 6'b100001);
        end
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
            checks++;
            if (flags !== 6'b100001 || bht_clr_idx_o !== W'(c)) begin
                failures++; $display("FAIL finit_restart c=%0d got=%b/%0d exp=%b/%0d", c, flags, bht_clr_idx_o, 6'b100001, c);
            end
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011000) begin
            failures++; $display("FAIL finit_run got=%b exp=%b", flags, 6'b011000);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(0, 0, 1, 3'd0, 1, 3'd5, 1);
        drive(0, 0, 1, 3'd0, 1, 3'd6, 0);
        drive(1, 0, 1, 3'd0, 1, 3'd7, 1);
        checks++;
        if (flags !== 6'b100000) begin
            failures++; $display("FAIL rmid_reset got=%b exp=%b", flags, 6'b100000);
        end
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
            checks++;
            if (flags !== 6'b100001 || bht_clr_idx_o !== W'(c)) begin
                failures++; $display("FAIL rmid_sweep c=%0d got=%b/%0d exp=%b/%0d", c, flags, bht_clr_idx_o, 6'b100001, c);
            end
        end
        drive(0, 0, 0, 3'd0, 0, 3'd0, 0);
        checks++;
        if (flags !== 6'b011000) begin
            failures++; $display("FAIL rmid_empty got=%b exp=%b", flags, 6'b011000);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_idle_drain();
        test_read_priority();
        test_full_fifo();
        test_flush_run();
        test_flush_init();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
